// File: rtl/idli_pkg.sv
// rtl/idli_pkg.sv - shared types for the idli core: slice counter, sync FSM state and access kind.
package idli_pkg;

  typedef logic [1:0] ctr_t;

  localparam int SLICE_W = 4;
  typedef logic [SLICE_W-1:0] slice_t;

  typedef enum logic [1:0] {
    SYNC_INIT  = 2'd0,
    SYNC_ADDR  = 2'd1,
    SYNC_FETCH = 2'd2,
    SYNC_DATA  = 2'd3
  } sync_state_t;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LD    = 2'd1,
    KIND_ST    = 2'd2
  } sync_kind_t;

endpackage

// File: rtl/idli_sync_m.sv
// rtl/idli_sync_m.sv - slice counter owner and SQI fetch/load/store sequencer.
module idli_sync_m
  import idli_pkg::*;
#(
  parameter int STARTUP_SLICES  = 2,
  parameter int REDIRECT_SLICES = 3
) (
  input  logic i_sync_gck,
  input  logic i_sync_rst,
  output ctr_t o_sync_ctr,
  input  logic i_sync_branch,
  input  logic i_sync_ld_req,
  input  logic i_sync_st_req,
  output logic o_sync_redirect,
  output logic o_sync_addr_sel,
  output logic o_sync_wr_en,
  output logic o_sync_data_vld,
  output logic o_sync_ack,
  output logic o_sync_stall
);

  localparam slice_t STARTUP_N  = slice_t'(STARTUP_SLICES);
  localparam slice_t REDIRECT_N = slice_t'(REDIRECT_SLICES);

  ctr_t        ctr_q;
  sync_state_t state_q, state_d;
  sync_kind_t  kind_q, kind_d;
  logic        sel_q, sel_d;
  slice_t      slice_q, slice_d;
  slice_t      slice_eff;

  always_ff @(posedge i_sync_gck) begin
    if (i_sync_rst) begin
      ctr_q   <= '0;
      state_q <= SYNC_INIT;
      kind_q  <= KIND_FETCH;
      sel_q   <= 1'b0;
      slice_q <= '0;
    end else begin
      ctr_q   <= ctr_q + 2'd1;
      state_q <= state_d;
      kind_q  <= kind_d;
      sel_q   <= sel_d;
      slice_q <= slice_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    sel_d     = sel_q;
    slice_d   = slice_q;
    // Reset clears the count, so INIT's first group stands for the full startup length.
    slice_eff = (state_q == SYNC_INIT && slice_q == '0) ? STARTUP_N : slice_q;
    if (ctr_q == 2'd3) begin
      slice_d = slice_eff - slice_t'(1);
      case (state_q)
        SYNC_INIT: begin
          if (slice_eff == slice_t'(1)) begin
            state_d = SYNC_ADDR;
            kind_d  = KIND_FETCH;
            sel_d   = 1'b0;
            slice_d = REDIRECT_N;
          end
        end
        SYNC_ADDR: begin
          if (slice_eff == slice_t'(1)) begin
            if (kind_q == KIND_FETCH) begin
              state_d = SYNC_FETCH;
              slice_d = '0;
            end else begin
              state_d = SYNC_DATA;
              slice_d = slice_t'(1);
            end
          end
        end
        SYNC_FETCH: begin
          slice_d = '0;
          if (i_sync_branch) begin
            state_d = SYNC_ADDR;
            kind_d  = KIND_FETCH;
            sel_d   = 1'b0;
            slice_d = REDIRECT_N;
          end else if (i_sync_st_req) begin
            state_d = SYNC_ADDR;
            kind_d  = KIND_ST;
            sel_d   = 1'b1;
            slice_d = REDIRECT_N;
          end else if (i_sync_ld_req) begin
            state_d = SYNC_ADDR;
            kind_d  = KIND_LD;
            sel_d   = 1'b1;
            slice_d = REDIRECT_N;
          end
        end
        default: begin
          // DATA is one group; always resume streaming from the PC.
          state_d = SYNC_ADDR;
          kind_d  = KIND_FETCH;
          sel_d   = 1'b0;
          slice_d = REDIRECT_N;
        end
      endcase
    end
  end

  assign o_sync_ctr      = ctr_q;
  assign o_sync_redirect = (state_q == SYNC_ADDR) && (ctr_q == 2'd0) && (slice_q == REDIRECT_N);
  assign o_sync_addr_sel = sel_q;
  assign o_sync_wr_en    = (state_q == SYNC_DATA) && (kind_q == KIND_ST);
  assign o_sync_data_vld = (state_q == SYNC_DATA) && (kind_q == KIND_LD);
  assign o_sync_ack      = (state_q == SYNC_DATA) && (ctr_q == 2'd3);
  assign o_sync_stall    = (state_q != SYNC_FETCH);

endmodule
